// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: parity encodings, receiver FSM state
//               type and the baud-tick divider calculation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Rounded CLK_HZ / (BAUD * OVERSAMPLE), never less than one.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        longint w_den;
        longint w_div;
        w_den = longint'(baud) * longint'(oversample);
        w_div = (longint'(clk_hz) + w_den / 2) / w_den;
        return (w_div < 1) ? 1 : int'(w_div);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
//==============================================================================
// Module      : uart_baud_tick
// Description : Oversampling tick divider with synchronous restart; emits a
//               one-cycle tick each time the counter wraps at DIV-1.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign tick = (r_cnt == c_last) && !restart;

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
//==============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver with parity/framing
//               error flags. Define UART_RX_MAJORITY_EN for 3-sample voting.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_d,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int                c_div      = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int                c_os_w     = $clog2(OVERSAMPLE);
    localparam int                c_bit_w    = $clog2(DATA_BITS);
    localparam logic [c_os_w-1:0] c_act_idx  = c_os_w'(OVERSAMPLE / 2);
    localparam logic [c_os_w-1:0] c_last_os  = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_os_w-1:0] c_os_one   = c_os_w'(1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
    localparam logic              c_last_stop = 1'(STOP_BITS - 1);
    localparam logic              c_odd       = (PARITY == PAR_ODD);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [1:0]           r_sync;
    logic                 r_rx_prev;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]           r_samp;
`else
    logic                 r_samp;
`endif
    logic [c_os_w-1:0]    r_os;
    logic [c_bit_w-1:0]   r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_perr_acc;
    logic                 r_ferr_acc;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_ready;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_busy;

    logic w_rx, w_fall, w_tick, w_act, w_bit, w_ferr_nxt, w_done;

    assign w_rx   = r_sync[1];
    assign w_fall = r_rx_prev & ~w_rx;
    // Decisions are taken one tick after the centre sample so both builds share latency.
    assign w_act  = w_tick && (r_os == c_act_idx);
`ifdef UART_RX_MAJORITY_EN
    assign w_bit  = (w_rx & r_samp[0]) | (w_rx & r_samp[1]) | (r_samp[0] & r_samp[1]);
`else
    assign w_bit  = r_samp;
`endif
    assign w_ferr_nxt = r_ferr_acc | ~w_bit;

    uart_baud_tick #(
        .DIV(c_div)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(r_state == ST_IDLE),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_samp    <= '1;
            r_os      <= '0;
        end else begin
            r_sync    <= {r_sync[0], rx_d};
            r_rx_prev <= w_rx;
            if (w_tick) begin
`ifdef UART_RX_MAJORITY_EN
                r_samp <= {r_samp[0], w_rx};
`else
                r_samp <= w_rx;
`endif
            end
            if (r_state == ST_IDLE) begin
                r_os <= '0;
            end else if (w_tick) begin
                r_os <= (r_os == c_last_os) ? '0 : r_os + c_os_one;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE:      if (w_fall) w_state_nxt = ST_START;
            ST_START:     if (w_act) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (w_act && (r_bit_idx == c_last_bit)) begin
                    w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY:    if (w_act) w_state_nxt = ST_STOP;
            ST_STOP: begin
                if (w_act && (r_stop_idx == c_last_stop)) begin
                    w_done      = 1'b1;
                    w_state_nxt = w_ferr_nxt ? ST_WAIT_HIGH : ST_IDLE;
                end
            end
            ST_WAIT_HIGH: if (w_rx) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_perr_acc   <= 1'b0;
            r_ferr_acc   <= 1'b0;
            r_data       <= '0;
            r_ready      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_par_acc  <= 1'b0;
                r_perr_acc <= 1'b0;
                r_ferr_acc <= 1'b0;
            end
            if (w_act) begin
                case (r_state)
                    ST_START: if (!w_bit) r_busy <= 1'b1;
                    ST_DATA: begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par_acc <= r_par_acc ^ w_bit;
                        r_bit_idx <= r_bit_idx + c_bit_one;
                    end
                    ST_PARITY: r_perr_acc <= r_par_acc ^ w_bit ^ c_odd;
                    ST_STOP: begin
                        r_ferr_acc <= w_ferr_nxt;
                        r_stop_idx <= r_stop_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (w_done) begin
                r_data       <= r_shift;
                r_parity_err <= (PARITY != PAR_NONE) && r_perr_acc;
                r_frame_err  <= w_ferr_nxt;
                r_ready      <= 1'b1;
                r_busy       <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign ready      = r_ready;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
//==============================================================================
// Module      : tb_uart_rx_param
// Description : Directed self-checking bench for uart_rx_param (8N1 instance
//               and a 7E1 instance sharing clock and reset).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_param;

    localparam int BIT_NS = 8680;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       ready_a, perr_a, ferr_a, busy_a;
    logic       ready_b, perr_b, ferr_b, busy_b;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rdy_a = 0, n_rdy_b = 0, n_busy_a = 0, n_busy_at_rdy = 0;
    logic [7:0] hist_prev = '0, hist_last = '0;

    uart_rx_param u_dut_a (
        .clk(clk), .rst(rst), .rx_d(rx_a), .data(data_a), .ready(ready_a),
        .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(2)) u_dut_b (
        .clk(clk), .rst(rst), .rx_d(rx_b), .data(data_b), .ready(ready_b),
        .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (ready_a) begin
            n_rdy_a++;
            hist_prev = hist_last;
            hist_last = data_a;
            if (busy_a) n_busy_at_rdy++;
        end
        if (busy_a) n_busy_a++;
        if (ready_b) n_rdy_b++;
    end

    task automatic drive(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic send(input int which, input logic [8:0] d, input int nbits,
                        input int par, input bit flip, input int bit_ns);
        logic p;
        p = 1'b0;
        drive(which, 1'b0);
        #(bit_ns);
        for (int i = 0; i < nbits; i++) begin
            drive(which, d[i]);
            p = p ^ d[i];
            #(bit_ns);
        end
        if (par == 2) begin
            drive(which, p ^ flip);
            #(bit_ns);
        end
        drive(which, 1'b1);
        #(bit_ns);
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk);
        n_chk++; if (ready_a !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_a); else n_pass++;
        n_chk++; if (data_a !== 8'h00) $display("FAIL reset_data: got %h want 00", data_a); else n_pass++;
        n_chk++; if (perr_a !== 1'b0) $display("FAIL reset_perr: got %b want 0", perr_a); else n_pass++;
        n_chk++; if (ferr_a !== 1'b0) $display("FAIL reset_ferr: got %b want 0", ferr_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
        rst = 1'b0;
        #2000;
    endtask

    task automatic test_basic;
        int r0, b0, br0;
        r0 = n_rdy_a; b0 = n_busy_a; br0 = n_busy_at_rdy;
        send(0, 9'h088, 8, 0, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        n_chk++; if (n_rdy_a - r0 !== 1) $display("FAIL basic_ready_count: got %0d want 1", n_rdy_a - r0); else n_pass++;
        n_chk++; if (data_a !== 8'h88) $display("FAIL basic_data: got %h want 88", data_a); else n_pass++;
        n_chk++; if (perr_a !== 1'b0) $display("FAIL basic_perr: got %b want 0", perr_a); else n_pass++;
        n_chk++; if (ferr_a !== 1'b0) $display("FAIL basic_ferr: got %b want 0", ferr_a); else n_pass++;
        n_chk++; if (n_busy_a - b0 < 3000) $display("FAIL basic_busy_seen: got %0d cycles want >=3000", n_busy_a - b0); else n_pass++;
        n_chk++; if (n_busy_at_rdy - br0 !== 0) $display("FAIL basic_busy_at_ready: got %0d want 0", n_busy_at_rdy - br0); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL basic_busy_idle: got %b want 0", busy_a); else n_pass++;
    endtask

    task automatic test_break;
        int r0;
        r0 = n_rdy_a;
        rx_a = 1'b0;
        #100000;
        n_chk++; if (n_rdy_a - r0 !== 1) $display("FAIL break_ready_count: got %0d want 1", n_rdy_a - r0); else n_pass++;
        n_chk++; if (ferr_a !== 1'b1) $display("FAIL break_ferr: got %b want 1", ferr_a); else n_pass++;
        n_chk++; if (data_a !== 8'h00) $display("FAIL break_data: got %h want 00", data_a); else n_pass++;
        rx_a = 1'b1;
        #20000;
        n_chk++; if (n_rdy_a - r0 !== 1) $display("FAIL break_no_extra_ready: got %0d want 1", n_rdy_a - r0); else n_pass++;
        send(0, 9'h055, 8, 0, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        n_chk++; if (data_a !== 8'h55) $display("FAIL break_next_data: got %h want 55", data_a); else n_pass++;
        n_chk++; if (ferr_a !== 1'b0) $display("FAIL break_next_ferr: got %b want 0", ferr_a); else n_pass++;
    endtask

    task automatic test_glitch;
        int r0, b0;
        r0 = n_rdy_a; b0 = n_busy_a;
        rx_a = 1'b0;
        #2000;
        rx_a = 1'b1;
        #20000;
        n_chk++; if (n_rdy_a - r0 !== 0) $display("FAIL glitch_ready: got %0d want 0", n_rdy_a - r0); else n_pass++;
        n_chk++; if (n_busy_a - b0 !== 0) $display("FAIL glitch_busy: got %0d cycles want 0", n_busy_a - b0); else n_pass++;
        n_chk++; if (data_a !== 8'h55) $display("FAIL glitch_data: got %h want 55", data_a); else n_pass++;
    endtask

    task automatic test_parity;
        int r0;
        r0 = n_rdy_b;
        send(1, 9'h041, 7, 2, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        n_chk++; if (n_rdy_b - r0 !== 1) $display("FAIL par_bad_ready: got %0d want 1", n_rdy_b - r0); else n_pass++;
        n_chk++; if (data_b !== 7'h41) $display("FAIL par_bad_data: got %h want 41", data_b); else n_pass++;
        n_chk++; if (perr_b !== 1'b1) $display("FAIL par_bad_perr: got %b want 1", perr_b); else n_pass++;
        send(1, 9'h041, 7, 2, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        n_chk++; if (n_rdy_b - r0 !== 2) $display("FAIL par_good_ready: got %0d want 2", n_rdy_b - r0); else n_pass++;
        n_chk++; if (perr_b !== 1'b0) $display("FAIL par_good_perr: got %b want 0", perr_b); else n_pass++;
        n_chk++; if (ferr_b !== 1'b0) $display("FAIL par_good_ferr: got %b want 0", ferr_b); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int r0;
        r0 = n_rdy_a;
        send(0, 9'h0A5, 8, 0, 1'b0, 8552);
        send(0, 9'h03C, 8, 0, 1'b0, 8552);
        #(2 * BIT_NS);
        n_chk++; if (n_rdy_a - r0 !== 2) $display("FAIL b2b_ready_count: got %0d want 2", n_rdy_a - r0); else n_pass++;
        n_chk++; if (hist_prev !== 8'hA5) $display("FAIL b2b_first: got %h want a5", hist_prev); else n_pass++;
        n_chk++; if (hist_last !== 8'h3C) $display("FAIL b2b_second: got %h want 3c", hist_last); else n_pass++;
        n_chk++; if (ferr_a !== 1'b0) $display("FAIL b2b_ferr: got %b want 0", ferr_a); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int r0;
        logic [7:0] d;
        d = 8'hC3;
        rx_a = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx_a = d[i];
            #(BIT_NS);
        end
        rx_a = d[4];
        #4000;
        n_chk++; if (busy_a !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy_a); else n_pass++;
        rst  = 1'b1;
        rx_a = 1'b1;
        #100;
        n_chk++; if (data_a !== 8'h00) $display("FAIL rstmid_data: got %h want 00", data_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_a); else n_pass++;
        n_chk++; if (ready_a !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", ready_a); else n_pass++;
        n_chk++; if ({perr_a, ferr_a} !== 2'b00) $display("FAIL rstmid_flags: got %b want 00", {perr_a, ferr_a}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #20000;
        r0 = n_rdy_a;
        send(0, 9'h00F, 8, 0, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        n_chk++; if (n_rdy_a - r0 !== 1) $display("FAIL rstmid_next_ready: got %0d want 1", n_rdy_a - r0); else n_pass++;
        n_chk++; if (data_a !== 8'h0F) $display("FAIL rstmid_next_data: got %h want 0f", data_a); else n_pass++;
        n_chk++; if (ferr_a !== 1'b0) $display("FAIL rstmid_next_ferr: got %b want 0", ferr_a); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_break();
        test_glitch();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver converting an asynchronous serial line into parallel words, with configurable baud rate, word length, parity and stop bits. It replaces the fixed 8N1 receiver in the UART path and sits between the board RX pin and the byte consumer. Oversampled start-bit qualification, parity and framing error reporting, and a one-cycle `ready` strobe per received word.

## Interface
- `CLK_HZ`, 50000000, system clock frequency in Hz
- `BAUD`, 115200, line baud rate
- `OVERSAMPLE`, 16, ticks per bit; even, ≥ 8
- `DATA_BITS`, 8, word length, 5–9
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, 1 or 2

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `rx_d`  in  1  serial line, idle high, asynchronous to `clk`
- `data`  out  DATA_BITS  last received word, LSB = first bit on the line
- `ready`  out  1  one-cycle strobe: `data` and error flags updated
- `parity_err`  out  1  parity mismatch on last word (0 when PARITY = 0)
- `frame_err`  out  1  a stop-bit sample was 0 on last word
- `busy`  out  1  high from qualified start bit until return to IDLE

## Operation
- `rx_d` passes through a 2-flop synchroniser; both flops reset to 1.
- Tick generator: `DIV = round(CLK_HZ / (BAUD*OVERSAMPLE))`, counter 0..DIV-1; one-cycle `tick` at wrap. Counter is held at 0 in IDLE and restarts on start-edge detection, so sampling phase aligns to the edge.
- Bit sample point: tick count `OVERSAMPLE/2` within each bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on synchronised falling edge → START.
  - START: at the mid-bit sample, line 1 → IDLE (glitch, nothing reported); line 0 → DATA.
  - DATA: shift in DATA_BITS samples LSB first; → PARITY if PARITY ≠ 0, else STOP.
  - PARITY: sample the parity bit and compare with computed parity (odd: XOR of data and parity bit = 1; even: = 0).
  - STOP: sample STOP_BITS stop bits. At the last stop sample, load `data`, `parity_err` and `frame_err`, and pulse `ready`. Next state: frame_err = 0 → IDLE (mid stop bit, allowing back-to-back frames); frame_err = 1 → WAIT_HIGH.
  - WAIT_HIGH: remain until the synchronised line is 1, then → IDLE. Break conditions yield exactly one `ready` with `frame_err`.
- `data` and the flags hold their values until the next `ready`. A glitch-rejected start does not alter them.
- Reset mid-frame: FSM → IDLE immediately and the partial word is discarded.

## Timing
- Reset values: `data` = 0, `ready` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0, FSM = IDLE.
- Edge-to-START latency: 2 clk (synchroniser) + 1 clk (edge detect).
- `ready` is asserted exactly one clk, registered, in the cycle after the last stop-bit sample tick.
- `busy` rises on entry to DATA and falls in the same cycle `ready` is asserted.
- Tolerated baud mismatch: ±2 % cumulative over a frame.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the majority of three samples at ticks `OVERSAMPLE/2-1`, `OVERSAMPLE/2` and `OVERSAMPLE/2+1`. Start qualification uses the same vote.
- Undefined: single sample at tick `OVERSAMPLE/2`.
- Latency to `ready` is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - parity encoding constants (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`)
  - FSM state typedef
  - a divider function computing DIV from CLK_HZ, BAUD and OVERSAMPLE
- Sub-module `uart_baud_tick`: divider counter with synchronous restart input and `tick` output. It is reused by the future transmitter.

## Test plan
- 50 MHz clk, default params; send start, bits 0,0,0,1,0,0,0,1, stop, 8680 ns per bit → one `ready`, `data` = 0x88, both errors 0.
- Stop bit driven 0 (rx held low 100 µs) → single `ready` with `frame_err` = 1; no further `ready` until the line returns high; the next valid frame 0x55 is received cleanly.
- Low pulse of 2000 ns on an idle line → no `ready`; `busy` stays 0; `data` unchanged.
- PARITY = 2, DATA_BITS = 7, send 0x41 with the parity bit inverted → `data` = 0x41, `parity_err` = 1; with correct parity → `parity_err` = 0.
- Two frames 0xA5, 0x3C back-to-back with no idle gap and BAUD offset +1.5 % → two `ready` pulses with correct data.
- Assert `rst` during bit 4 of a frame → outputs return to reset values; the following full frame 0x0F is received correctly.
